// File: rtl/bg_pkg.sv
// Shared types and colour constants for the screen background generator.
package bg_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [1:0] {BG_PLAY, BG_PAUSE, BG_GAMEOVER, BG_WIN} bg_state_e;

  localparam rgb332_t PALETTE [4] = '{
    rgb332_t'(8'h02),  // play: dark blue
    rgb332_t'(8'h49),  // pause: grey
    rgb332_t'(8'hC0),  // game over: dark red
    rgb332_t'(8'h1C)   // win: green
  };

  localparam rgb332_t BORDER_COLOR = rgb332_t'(8'hFF);

endpackage

// File: rtl/bg_frame_tick.sv
// One-clock pulse on the first clock the scan position reaches (0,0); holding there
// for several clocks still yields a single tick per frame.
module bg_frame_tick (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        tick
);

  logic origin;
  logic prev_origin;

  assign origin = (pixelX == 11'd0) && (pixelY == 11'd0);
  assign tick   = origin && !prev_origin;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_origin <= 1'b0;
    end else begin
      prev_origin <= origin;
    end
  end

endmodule

// File: rtl/screen_background_gen.sv
// Full-screen background: per-state palette colour faded in on state change, plus a border
// bracket that blinks in game over. Define BG_GRADIENT_EN for a vertical blue gradient.
module screen_background_gen
  import bg_pkg::*;
#(
  parameter int unsigned X_FRAME_SIZE    = 639,
  parameter int unsigned Y_FRAME_SIZE    = 479,
  parameter int unsigned STATE_W         = 2,
  parameter int unsigned BORDER_W        = 10,
  parameter int unsigned FADE_STEPS      = 8,
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned BLINK_FRAMES    = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] bgState,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  output logic [7:0]         BG_RGB,
  output logic               fadeDone
);

  localparam int unsigned LVL_W = $clog2(FADE_STEPS);
  localparam int unsigned FRM_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [LVL_W-1:0] FADE_MAX = LVL_W'(FADE_STEPS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_STEP - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [10:0] X_MAX = 11'(X_FRAME_SIZE);
  localparam logic [10:0] Y_MAX = 11'(Y_FRAME_SIZE);
  localparam logic [10:0] BW    = 11'(BORDER_W);
  localparam logic [10:0] X_HI  = 11'(X_FRAME_SIZE - BORDER_W);
  localparam logic [10:0] Y_HI  = 11'(Y_FRAME_SIZE - BORDER_W);

  logic               tick;
  logic [STATE_W-1:0] cur_state;
  logic [LVL_W-1:0]   fade_lvl;
  logic [FRM_W-1:0]   frame_cnt;
  logic [BLK_W-1:0]   blink_cnt;
  logic               blink_on;

  rgb332_t          base;
  rgb332_t          faded;
  rgb332_t          pix_rgb;
  logic [LVL_W:0]   mult;
  logic [LVL_W+2:0] r_prod;
  logic [LVL_W+2:0] g_prod;
  logic [LVL_W+1:0] b_prod;
  logic             in_range;
  logic             in_border;
`ifdef BG_GRADIENT_EN
  logic [2:0]       b_sum;
`endif

  bg_frame_tick u_frame_tick (
    .clk    (clk),
    .reset  (reset),
    .pixelX (pixelX),
    .pixelY (pixelY),
    .tick   (tick)
  );

  assign fadeDone = (fade_lvl == FADE_MAX);

  always_comb begin
    base   = PALETTE[cur_state];
    mult   = {1'b0, fade_lvl} + (LVL_W + 1)'(1);
    r_prod = (LVL_W + 3)'(base.r) * (LVL_W + 3)'(mult);
    g_prod = (LVL_W + 3)'(base.g) * (LVL_W + 3)'(mult);
    b_prod = (LVL_W + 2)'(base.b) * (LVL_W + 2)'(mult);
    // Selecting the bits above LVL_W is the divide by FADE_STEPS.
    faded.r = r_prod[LVL_W +: 3];
    faded.g = g_prod[LVL_W +: 3];
    faded.b = b_prod[LVL_W +: 2];
`ifdef BG_GRADIENT_EN
    b_sum   = {1'b0, faded.b} + {1'b0, pixelY[8:7]};
    faded.b = b_sum[2] ? 2'd3 : b_sum[1:0];
`endif

    in_range  = (pixelX <= X_MAX) && (pixelY <= Y_MAX);
    in_border = (pixelX < BW) || (pixelX > X_HI) || (pixelY < BW) || (pixelY > Y_HI);

    if (!in_range) begin
      pix_rgb = rgb332_t'(8'h00);
    end else if (in_border && blink_on) begin
      pix_rgb = BORDER_COLOR;
    end else begin
      pix_rgb = faded;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      BG_RGB    <= 8'h00;
      cur_state <= '0;
      fade_lvl  <= FADE_MAX;
      frame_cnt <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      BG_RGB <= pix_rgb;

      // A state change overrides any same-clock tick and restarts the fade.
      if (bgState != cur_state) begin
        cur_state <= bgState;
        fade_lvl  <= '0;
        frame_cnt <= '0;
      end else if (tick && (fade_lvl != FADE_MAX)) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt <= '0;
          fade_lvl  <= fade_lvl + LVL_W'(1);
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end

      if (cur_state == STATE_W'(BG_GAMEOVER)) begin
        if (tick) begin
          if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
          end
        end
      end else begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_screen_background_gen.sv
// Directed, table-driven bench for screen_background_gen (default parameters).
module tb_screen_background_gen;

`ifdef BG_GRADIENT_EN
  localparam bit GRAD = 1'b1;
`else
  localparam bit GRAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  bgState;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [7:0]  BG_RGB;
  logic        fadeDone;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  st;
    logic [10:0] x;
    logic [10:0] y;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  screen_background_gen dut (
    .clk      (clk),
    .reset    (reset),
    .bgState  (bgState),
    .pixelX   (pixelX),
    .pixelY   (pixelY),
    .BG_RGB   (BG_RGB),
    .fadeDone (fadeDone)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: BG_RGB=%02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: fadeDone=%0b expected %0b", name, act, exp);
    end
  endtask

  task automatic set_pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
  endtask

  // One frame: visit the origin for one clock, then return to (x,y) for one clock.
  task automatic frames(input int n, input int x, input int y);
    for (int i = 0; i < n; i++) begin
      set_pix(0, 0);
      step();
      set_pix(x, y);
      step();
    end
  endtask

  // Dark red faded to level lvl, at a region-(c) pixel on row 200 (pixelY[8:7] = 1).
  function automatic logic [7:0] red_at(input int lvl);
    logic [7:0] v;
    v      = 8'h00;
    v[7:5] = 3'((6 * (lvl + 1)) >> 3);
    v[1:0] = GRAD ? 2'd1 : 2'd0;
    return v;
  endfunction

  initial begin
    reset   = 1'b1;
    bgState = 2'd0;
    set_pix(100, 100);

    // Reset behaviour
    step();
    check8("reset_rgb_0", BG_RGB, 8'h00);
    check1("reset_done", fadeDone, 1'b1);
    step();
    check8("reset_rgb_1", BG_RGB, 8'h00);
    reset = 1'b0;
    step();
    check8("after_reset_blue", BG_RGB, 8'h02);
    check1("after_reset_done", fadeDone, 1'b1);

    // Fade from play to win
    bgState = 2'd3;
    step();
    check8("change_latency", BG_RGB, 8'h02);
    step();
    check8("win_lvl0", BG_RGB, 8'h00);
    check1("win_lvl0_done", fadeDone, 1'b0);
    frames(4, 100, 100);
    check8("win_lvl1", BG_RGB, 8'h04);
    frames(23, 100, 100);
    check8("win_lvl6", BG_RGB, 8'h18);
    check1("win_lvl6_done", fadeDone, 1'b0);
    frames(1, 100, 100);
    check8("win_full", BG_RGB, 8'h1C);
    check1("win_full_done", fadeDone, 1'b1);

    // Holding the origin produces a single tick
    bgState = 2'd0;
    step();
    bgState = 2'd3;
    step();
    check1("hold_restart_done", fadeDone, 1'b0);
    set_pix(0, 0);
    for (int i = 0; i < 5; i++) step();
    set_pix(100, 100);
    step();
    check8("hold_one_tick", BG_RGB, 8'h00);
    frames(2, 100, 100);
    check8("hold_three_ticks", BG_RGB, 8'h00);
    frames(1, 100, 100);
    check8("hold_four_ticks", BG_RGB, 8'h04);

    // Pixel classification at full fade
    vecs.push_back('{2'd0, 11'd100, 11'd100, 8'h02, "play_centre"});
    vecs.push_back('{2'd0, 11'd700, 11'd100, 8'h00, "play_x_out"});
    vecs.push_back('{2'd0, 11'd10,  11'd500, 8'h00, "play_y_out"});
    vecs.push_back('{2'd0, 11'd640, 11'd0,   8'h00, "play_x640"});
    vecs.push_back('{2'd0, 11'd5,   11'd200, 8'hFF, "play_left_border"});
    vecs.push_back('{2'd0, 11'd9,   11'd100, 8'hFF, "play_x9"});
    vecs.push_back('{2'd0, 11'd10,  11'd100, 8'h02, "play_x10"});
    vecs.push_back('{2'd0, 11'd629, 11'd100, 8'h02, "play_x629"});
    vecs.push_back('{2'd0, 11'd630, 11'd100, 8'hFF, "play_x630"});
    vecs.push_back('{2'd0, 11'd100, 11'd9,   8'hFF, "play_y9"});
    vecs.push_back('{2'd0, 11'd100, 11'd10,  8'h02, "play_y10"});
    vecs.push_back('{2'd0, 11'd100, 11'd469, GRAD ? 8'h03 : 8'h02, "play_y469"});
    vecs.push_back('{2'd0, 11'd100, 11'd470, 8'hFF, "play_y470"});
    vecs.push_back('{2'd0, 11'd639, 11'd479, 8'hFF, "play_corner"});
    vecs.push_back('{2'd0, 11'd100, 11'd400, GRAD ? 8'h03 : 8'h02, "play_y400"});
    vecs.push_back('{2'd3, 11'd100, 11'd100, 8'h1C, "win_centre"});
    vecs.push_back('{2'd3, 11'd700, 11'd100, 8'h00, "win_x_out"});
    vecs.push_back('{2'd3, 11'd10,  11'd500, 8'h00, "win_y_out"});
    vecs.push_back('{2'd3, 11'd0,   11'd479, 8'hFF, "win_corner"});
    vecs.push_back('{2'd3, 11'd100, 11'd400, GRAD ? 8'h1F : 8'h1C, "win_y400"});
    vecs.push_back('{2'd1, 11'd100, 11'd100, 8'h49, "pause_centre"});
    vecs.push_back('{2'd1, 11'd700, 11'd100, 8'h00, "pause_x_out"});
    vecs.push_back('{2'd1, 11'd10,  11'd500, 8'h00, "pause_y_out"});
    vecs.push_back('{2'd1, 11'd100, 11'd470, 8'hFF, "pause_bottom"});
    vecs.push_back('{2'd1, 11'd100, 11'd300, GRAD ? 8'h4B : 8'h49, "pause_y300"});

    foreach (vecs[i]) begin
      if (vecs[i].st != bgState) begin
        bgState = vecs[i].st;
        set_pix(100, 100);
        step();
        frames(32, 100, 100);
      end
      set_pix(int'(vecs[i].x), int'(vecs[i].y));
      step();
      check8(vecs[i].name, BG_RGB, vecs[i].exp);
    end

    // State change on a tick clock mid-fade
    bgState = 2'd3;
    set_pix(100, 100);
    step();
    frames(16, 100, 100);
    check8("mid_lvl4", BG_RGB, 8'h10);
    frames(3, 100, 100);
    set_pix(0, 0);
    bgState = 2'd2;
    step();
    set_pix(100, 100);
    step();
    check8("tick_change_lvl0", BG_RGB, 8'h00);
    check1("tick_change_done", fadeDone, 1'b0);
    frames(3, 100, 100);
    check8("tick_ignored", BG_RGB, 8'h00);
    frames(1, 100, 100);
    check8("tick_change_lvl1", BG_RGB, 8'h20);

    // Border blink in game over
    bgState = 2'd0;
    set_pix(5, 200);
    step();
    step();
    bgState = 2'd2;
    step();
    for (int n = 1; n <= 91; n++) begin
      int lvl;
      lvl = (n / 4 > 7) ? 7 : n / 4;
      frames(1, 5, 200);
      check8($sformatf("blink_frame%0d", n), BG_RGB,
             (((n / 30) % 2) == 0) ? 8'hFF : red_at(lvl));
    end
    set_pix(700, 100);
    step();
    check8("gameover_x_out", BG_RGB, 8'h00);
    set_pix(5, 200);
    bgState = 2'd0;
    step();
    check8("leave_gameover_0", BG_RGB, 8'hC0 | (GRAD ? 8'h01 : 8'h00));
    step();
    check8("leave_gameover_1", BG_RGB, GRAD ? 8'h01 : 8'h00);
    step();
    check8("leave_gameover_border", BG_RGB, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
